wash_cycle_sensors: RTL
=======================

Name: wash_cycle_sensors

Overview:
- Sensor and timer front-end for the washer control FSM.
- Conditions the raw water-level sensor into `full`.
- Times the shake phase to produce `Time` and the turn/spin phase to produce `dry`.
- Watches the fill valve for a timeout.
- Consumes the FSM's `valve`, `shake_mode` and `turn_mode` outputs and drives its `full`, `Time` and `dry` inputs. It is the stage directly upstream of the controller.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required to change `full`.
- SHAKE_CYCLES, 16: cycles `shake_mode` must be high before `Time` asserts.
- TURN_CYCLES, 8: cycles `turn_mode` must be high before `dry` asserts.
- FILL_TIMEOUT, 64: cycles `valve` may stay high without `full` before `fill_fault` asserts.
- CNT_W, 8: width of all internal counters. Every cycle parameter is in the range 1..2^CNT_W-1.

Ports:
- clock  input  1  system clock; all flops on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- level_raw  input  1  raw water-level switch, asynchronous to clock.
- valve  input  1  fill-valve command from the control FSM.
- shake_mode  input  1  shake-phase indicator from the control FSM.
- turn_mode  input  1  turn-phase indicator from the control FSM.
- full  output  1  debounced tank-full flag.
- Time  output  1  shake duration elapsed.
- dry  output  1  turn duration elapsed.
- fill_fault  output  1  sticky: fill timed out.
- mode_fault  output  1  sticky: more than one of valve/shake_mode/turn_mode high in the same cycle.

Behaviour:
- Reset (async, active-high) clears every output, the synchroniser, and all counters to 0.
- Synchroniser: `level_raw` passes through two flops to give `level_s`.
- Debounce: `db_cnt` counts consecutive cycles in which `level_s` differs from `full`.
  - It resets to 0 on any cycle where they agree.
  - When `db_cnt` reaches DEBOUNCE_CYCLES-1 and they still differ, `full` toggles on that edge and `db_cnt` returns to 0.
  - Result: a clean level change appears on `full` 2+DEBOUNCE_CYCLES edges after `level_raw` changes.
  - Glitches shorter than DEBOUNCE_CYCLES synchronised cycles never reach `full`.
- Shake timer:
  - While `shake_mode` is sampled high, `sh_cnt` increments and saturates at SHAKE_CYCLES.
  - `Time` is registered and goes high on the edge where `sh_cnt` reaches SHAKE_CYCLES, i.e. the SHAKE_CYCLES-th edge with `shake_mode` high.
  - `Time` holds while `shake_mode` stays high.
  - Any edge with `shake_mode` low clears `sh_cnt` and `Time` together (no partial-credit carry-over).
- Turn timer: identical to the shake timer, using `turn_mode`, `tr_cnt`, TURN_CYCLES and `dry`.
- Fill watchdog:
  - While `valve` is high and `full` is low, `fl_cnt` increments and saturates.
  - On the edge where `fl_cnt` reaches FILL_TIMEOUT, `fill_fault` sets.
  - `fl_cnt` clears whenever `valve` is low or `full` is high.
  - `fill_fault` stays set until reset.
- Mode fault:
  - Any edge sampling two or more of valve/shake_mode/turn_mode high sets `mode_fault` (sticky until reset).
  - On that edge, `sh_cnt`, `tr_cnt` and `fl_cnt` are cleared, and `Time` and `dry` go low.
  - Debounce continues unaffected.
- Simultaneous events:
  - A mode drop wins over terminal count; the output does not assert on that edge.
  - `full` rising on the same edge as the watchdog terminal count still sets `fill_fault`, because the watchdog samples the pre-edge `full`.
- Reset mid-operation: all timers restart from 0 after reset deasserts, and `full` re-qualifies from 0 through the debounce path.
- All counters compare against unsigned CNT_W-bit constants and never wrap.

Optional Feature:
- Macro: WASH_DOOR_PAUSE_EN.
- When defined:
  - Adds input port `door_open` (1 bit, synchronous to clock).
  - While `door_open` is high, `sh_cnt`, `tr_cnt` and `fl_cnt` hold their values; no increment and no clear, even if a mode input drops.
  - `Time`, `dry` and `fill_fault` hold their current values.
  - Debounce and `mode_fault` detection continue.
- When undefined: the port does not exist and timers behave as described above.

Test Plan:
- Debounce: reset, then raise `level_raw` and hold it high → `full` rises exactly 6 edges later (defaults); a 3-cycle high pulse on `level_raw` → `full` stays 0.
- Shake timing: hold `shake_mode` high for 20 cycles → `Time` rises on the 16th edge and stays high; drop `shake_mode` → `Time` 0 on the next edge. Raise it again for 10 cycles → `Time` stays 0.
- Turn timing: hold `turn_mode` high for 8 cycles → `dry` rises on the 8th edge; a 7-cycle pulse → `dry` never asserts.
- Fill watchdog: `valve` high with `level_raw` low for 70 cycles → `fill_fault` sets on the 64th edge and stays set after `valve` drops; a fresh run where `full` arrives at cycle 30 → `fill_fault` stays 0.
- Mode fault: `shake_mode` high for 10 cycles, then `turn_mode` also high for 1 cycle → `mode_fault` = 1 (sticky) and `sh_cnt` cleared; `Time` does not assert until 16 further clean shake cycles.
- Async reset: assert `reset` for 1 ns mid-shake at count 12 → all outputs 0 immediately; `Time` needs 16 fresh cycles after release. With WASH_DOOR_PAUSE_EN, `door_open` high for 5 cycles at shake count 10 → `Time` rises 21 edges after `shake_mode` first rose.

Source files
------------

// File: rtl/wash_cycle_sensors.sv
// Sensor/timer front-end for the washer controller: level debounce, shake/turn timers,
// fill watchdog and mode-conflict detection. Define WASH_DOOR_PAUSE_EN to add door_open pause.
module wash_cycle_sensors #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SHAKE_CYCLES    = 16,
    parameter int TURN_CYCLES     = 8,
    parameter int FILL_TIMEOUT    = 64,
    parameter int CNT_W           = 8
) (
    input  logic clock,
    input  logic reset,
`ifdef WASH_DOOR_PAUSE_EN
    input  logic door_open,
`endif
    input  logic level_raw,
    input  logic valve,
    input  logic shake_mode,
    input  logic turn_mode,
    output logic full,
    output logic Time,
    output logic dry,
    output logic fill_fault,
    output logic mode_fault
);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SH_MAX  = CNT_W'(SHAKE_CYCLES);
    localparam logic [CNT_W-1:0] TR_MAX  = CNT_W'(TURN_CYCLES);
    localparam logic [CNT_W-1:0] FL_MAX  = CNT_W'(FILL_TIMEOUT);

    logic             sync1_q, level_s_q;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] sh_cnt_q, sh_cnt_d, sh_inc;
    logic [CNT_W-1:0] tr_cnt_q, tr_cnt_d, tr_inc;
    logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d, fl_inc;
    logic             full_q, full_d;
    logic             time_q, time_d;
    logic             dry_q, dry_d;
    logic             fill_fault_q, fill_fault_d;
    logic             mode_fault_q, mode_fault_d;
    logic             mode_err, pause;

`ifdef WASH_DOOR_PAUSE_EN
    assign pause = door_open;
`else
    assign pause = 1'b0;
`endif

    assign mode_err = (valve & shake_mode) | (valve & turn_mode) | (shake_mode & turn_mode);
    assign sh_inc   = sh_cnt_q + 1'b1;
    assign tr_inc   = tr_cnt_q + 1'b1;
    assign fl_inc   = fl_cnt_q + 1'b1;

    always_comb begin
        db_cnt_d     = '0;
        full_d       = full_q;
        sh_cnt_d     = sh_cnt_q;
        time_d       = time_q;
        tr_cnt_d     = tr_cnt_q;
        dry_d        = dry_q;
        fl_cnt_d     = fl_cnt_q;
        fill_fault_d = fill_fault_q;
        mode_fault_d = mode_fault_q | mode_err;

        if (level_s_q != full_q) begin
            if (db_cnt_q == DB_LAST) full_d = ~full_q;
            else                     db_cnt_d = db_cnt_q + 1'b1;
        end

        // A paused door freezes every timer, including its clear path.
        if (!pause) begin
            if (mode_err || !shake_mode) begin
                sh_cnt_d = '0;
                time_d   = 1'b0;
            end else if (sh_cnt_q != SH_MAX) begin
                sh_cnt_d = sh_inc;
                time_d   = (sh_inc == SH_MAX);
            end

            if (mode_err || !turn_mode) begin
                tr_cnt_d = '0;
                dry_d    = 1'b0;
            end else if (tr_cnt_q != TR_MAX) begin
                tr_cnt_d = tr_inc;
                dry_d    = (tr_inc == TR_MAX);
            end

            // Watchdog looks at pre-edge full, so a same-edge fill still faults.
            if (mode_err || !valve || full_q) begin
                fl_cnt_d = '0;
            end else if (fl_cnt_q != FL_MAX) begin
                fl_cnt_d     = fl_inc;
                fill_fault_d = fill_fault_q | (fl_inc == FL_MAX);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            level_s_q    <= 1'b0;
            db_cnt_q     <= '0;
            full_q       <= 1'b0;
            sh_cnt_q     <= '0;
            time_q       <= 1'b0;
            tr_cnt_q     <= '0;
            dry_q        <= 1'b0;
            fl_cnt_q     <= '0;
            fill_fault_q <= 1'b0;
            mode_fault_q <= 1'b0;
        end else begin
            sync1_q      <= level_raw;
            level_s_q    <= sync1_q;
            db_cnt_q     <= db_cnt_d;
            full_q       <= full_d;
            sh_cnt_q     <= sh_cnt_d;
            time_q       <= time_d;
            tr_cnt_q     <= tr_cnt_d;
            dry_q        <= dry_d;
            fl_cnt_q     <= fl_cnt_d;
            fill_fault_q <= fill_fault_d;
            mode_fault_q <= mode_fault_d;
        end
    end

    assign full       = full_q;
    assign Time       = time_q;
    assign dry        = dry_q;
    assign fill_fault = fill_fault_q;
    assign mode_fault = mode_fault_q;
endmodule
